// File: rtl/ac_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ac_cmd_scheduler
//   Holds the air-conditioner settings (power, mode, temperature), turns key
//   presses into IR command frames and sends each command REPEATS times,
//   separated by a fixed gap, through an external frame transmitter.
//
// Parameters
//   GAP_CYCLES : cycles from a tx_done pulse to the repeated tx_start (>= 2)
//   REPEATS    : frames sent per command, 1..3
//   TIMEOUT    : max cycles from tx_start to tx_done, counting the tx_start
//                cycle itself (>= 2)
//
// Ports
//   clk, rst        : system clock (rising edge), async active-high reset
//   key_power/mode/up/down : debounced single-cycle key pulses
//   tx_busy, tx_done: transmitter status / end-of-frame pulse
//   tx_start        : single-cycle frame-start request
//   tx_data35/32    : frame segments, stable from BUILD to the next BUILD
//   err             : single-cycle pulse when a frame times out
//   frame_cnt       : completed frames, wraps 255 -> 0
//   power_on        : current power setting
// ---------------------------------------------------------------------------
module ac_cmd_scheduler #(
  parameter int GAP_CYCLES = 2500000,
  parameter int REPEATS    = 2,
  parameter int TIMEOUT    = 4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_power,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [34:0] tx_data35,
  output logic [31:0] tx_data32,
  output logic        err,
  output logic [7:0]  frame_cnt,
  output logic        power_on
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Both counters start at 0 in the cycle after tx_done / tx_start, so the
  // terminal value is two below the requested distance.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [1:0]    REP_MAX  = 2'(REPEATS);

  localparam logic [3:0]  TEMP_MAX   = 4'd14;   // 30 C
  localparam logic [3:0]  TEMP_RESET = 4'd10;   // 26 C
  localparam logic [2:0]  MODE_MAX   = 3'd4;
  localparam logic [26:0] FRAME_TAIL = 27'h0050A52;

  typedef enum logic [2:0] {IDLE, BUILD, START, WAIT_DONE, GAP} state_e;

  state_e        state_q;
  logic          power_q,   power_d;
  logic [2:0]    mode_q,    mode_d;
  logic [3:0]    temp_q,    temp_d;
  logic          key_pend;
  logic          pend_q;
  logic [1:0]    rep_q;
  logic [1:0]    rep_inc;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    chk;
  logic          tx_start_q, err_q;
  logic [34:0]   data35_q;
  logic [31:0]   data32_q;
  logic [7:0]    frame_cnt_q;

  // Settings update. key_power overrides every other key in the same cycle;
  // up and down together cancel out.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    power_d  = power_q;
    mode_d   = mode_q;
    temp_d   = temp_q;
    key_pend = 1'b0;
    if (key_power) begin
      power_d  = ~power_q;
      key_pend = 1'b1;
    end else if (power_q) begin
      if (key_mode) begin
        mode_d   = (mode_q == MODE_MAX) ? 3'd0 : mode_q + 3'd1;
        key_pend = 1'b1;
      end
      if (key_up && !key_down && temp_q != TEMP_MAX) begin
        temp_d   = temp_q + 4'd1;
        key_pend = 1'b1;
      end else if (key_down && !key_up && temp_q != 4'd0) begin
        temp_d   = temp_q - 4'd1;
        key_pend = 1'b1;
      end
    end
  end

  // 4-bit wrapping checksum of the settings.
  assign chk     = {1'b0, mode_q} + {3'b000, power_q} + temp_q;
  assign rep_inc = rep_q + 2'd1;

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in this block deliberately override the defaults above them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      power_q     <= 1'b0;
      mode_q      <= 3'd0;
      temp_q      <= TEMP_RESET;
      pend_q      <= 1'b0;
      rep_q       <= 2'd0;
      gap_q       <= '0;
      tmo_q       <= '0;
      tx_start_q  <= 1'b0;
      err_q       <= 1'b0;
      data35_q    <= '0;
      data32_q    <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      power_q    <= power_d;
      mode_q     <= mode_d;
      temp_q     <= temp_d;
      pend_q     <= pend_q | key_pend;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pend_q && !tx_busy) begin
            state_q <= BUILD;
            // A key arriving on this very edge keeps the flag set, so it is
            // never lost.
            pend_q  <= key_pend;
          end
        end
        BUILD: begin
          data35_q   <= {mode_q, power_q, temp_q, FRAME_TAIL};
          data32_q   <= {28'h0000000, chk};
          rep_q      <= 2'd0;
          tx_start_q <= 1'b1;
          state_q    <= START;
        end
        START: begin
          tmo_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            rep_q       <= rep_inc;
            gap_q       <= '0;
            state_q     <= (rep_inc < REP_MAX) ? GAP : IDLE;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            pend_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            tx_start_q <= 1'b1;
            state_q    <= START;
          end else begin
            gap_q <= gap_q + GAP_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start  = tx_start_q;
  assign err       = err_q;
  assign tx_data35 = data35_q;
  assign tx_data32 = data32_q;
  assign frame_cnt = frame_cnt_q;
  assign power_on  = power_q;

endmodule

// File: doc/ac_cmd_scheduler.md
AC_CMD_SCHEDULER -- requirements
Module: ac_cmd_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2500000: idle cycles between repeated frames (20 ms at 125 MHz).
REQ-002 SHALL have parameter REPEATS, default 2: frames sent per command, range 1..3.
REQ-003 SHALL have parameter TIMEOUT, default 4000000: max cycles from tx_start to tx_done.
REQ-004 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports key_power, key_mode, key_up, key_down, each input, 1: debounced single-cycle key pulses.
REQ-007 SHALL have port tx_busy, input, 1: transmitter is sending a frame.
REQ-008 SHALL have port tx_done, input, 1: single-cycle pulse at the end of a frame.
REQ-009 SHALL have port tx_start, output, 1: single-cycle frame-start request.
REQ-010 SHALL have port tx_data35, output, 35: first frame segment, MSB sent first.
REQ-011 SHALL have port tx_data32, output, 32: second frame segment, MSB sent first.
REQ-012 SHALL have port err, output, 1: single-cycle pulse on a timeout.
REQ-013 SHALL have port frame_cnt, output, 8: count of completed frames, wraps 255->0.
REQ-014 SHALL have port power_on, output, 1: current power setting.

Function
REQ-015 SHALL hold settings power (1 bit), mode (0..4) and temp (16..30 C), stored as temp_code = temp-16.
REQ-016 SHALL toggle power on key_power; this always sets the pending flag.
REQ-017 SHALL, while power=1, advance mode on key_mode (4 wraps to 0) and set pending.
REQ-018 SHALL, while power=1, make key_up increment temp and key_down decrement it, saturating at 30 and 16; SHALL set pending only if temp changed.
REQ-019 SHALL ignore key_mode, key_up and key_down while power=0 (no change, no pending).
REQ-020 SHALL, for keys asserted in the same cycle, apply key_power only; with key_up and key_down together, SHALL make no temp change.
REQ-021 SHALL update settings in any FSM state; keys received during a send sequence SHALL coalesce into one pending flag.
REQ-022 SHALL use FSM states IDLE, BUILD, START, WAIT_DONE, GAP.
REQ-023 IDLE: SHALL move to BUILD when pending=1 and tx_busy=0, and SHALL clear pending on that transition.
REQ-024 BUILD (1 cycle): SHALL latch tx_data35 = {mode[2:0], power, temp_code[3:0], 27'h0050A52}.
REQ-025 BUILD: SHALL latch tx_data32 = {28'h0000000, chk}, where chk = (mode + power + temp_code) mod 16, using 4-bit wrapping addition.
REQ-026 BUILD: SHALL reset the repeat counter to 0.
REQ-027 START: SHALL pulse tx_start for exactly one cycle, then enter WAIT_DONE.
REQ-028 tx_data35 and tx_data32 SHALL stay stable from BUILD until the next BUILD.
REQ-029 WAIT_DONE: on tx_done, SHALL increment frame_cnt and the repeat counter.
REQ-030 WAIT_DONE: if the repeat counter is still below REPEATS, SHALL go to GAP; otherwise SHALL go to IDLE.
REQ-031 GAP: SHALL wait exactly GAP_CYCLES cycles, then return to START with the same data; it SHALL NOT rebuild.
REQ-032 SHALL send a newer pending command only after the current repeat sequence ends (IDLE->BUILD).
REQ-033 WAIT_DONE: if TIMEOUT cycles pass without tx_done, SHALL pulse err, leave frame_cnt unchanged, set pending=1 and go to IDLE.
REQ-034 SHALL ignore tx_done outside WAIT_DONE.
REQ-035 SHALL need exactly 3 cycles from a key pulse in IDLE to tx_start (pending set, BUILD, START), given tx_busy=0.

Reset
REQ-036 On rst SHALL reset: state IDLE, power=0, mode=0, temp=26, pending=0, counters 0.
REQ-037 On rst SHALL reset outputs: tx_start=0, err=0, frame_cnt=0, power_on=0, tx_data35=0, tx_data32=0.
REQ-038 Reset asserted mid-sequence SHALL abort at once with no further tx_start; after release, no frame SHALL be sent until a new key arrives.

Verification (GAP_CYCLES=10, TIMEOUT=50, REPEATS=2, transmitter model returns tx_done 20 cycles after tx_start)
REQ-039 key_power pulse after reset -> tx_start 3 cycles later; tx_data35 = {3'd0,1'b1,4'd10,27'h0050A52}; tx_data32 low nibble = 4'hB; second tx_start 10 cycles after first tx_done; frame_cnt=2.
REQ-040 key_up pressed 5 times with power on -> temp saturates at 30; last frame temp_code=14, chk=(0+1+14) mod 16=4'hF.
REQ-041 key_mode pulsed during WAIT_DONE -> current sequence finishes unchanged; one new sequence follows carrying mode=1.
REQ-042 key_up and key_down in the same cycle -> no pending, no tx_start; key_power plus key_mode together -> power toggles, mode unchanged.
REQ-043 Transmitter never returns tx_done -> err pulse 50 cycles after tx_start; frame is retried from IDLE; frame_cnt unchanged.
REQ-044 rst asserted during GAP -> all outputs at reset values on the next cycle; no tx_start after release without a key pulse.
